// File: rtl/i2c_master_rw.sv
// I2C master: START, {addr,rw}, then up to MAX_BYTES write or read data bytes with ACK/NACK, then STOP.
// Defining I2C_CLK_STRETCH_EN makes the master honour slave clock stretching while SCL is released.
module i2c_master_rw #(
   parameter int CLOCK_DIVIDER = 12500,
   parameter int MAX_BYTES     = 8,
   parameter int LSB_FIRST     = 0,
   parameter int BW            = $clog2(MAX_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   rw,
   input  logic [6:0]             addr,
   input  logic [BW-1:0]          num_bytes,
   input  logic [8*MAX_BYTES-1:0] wr_data,
   output logic [8*MAX_BYTES-1:0] rd_data,
   output logic                   busy,
   output logic                   done,
   output logic                   ack_error,
   output logic                   sda_oe,
   input  logic                   sda_in,
   output logic                   scl_oe,
   input  logic                   scl_in
);
   localparam int Q  = CLOCK_DIVIDER / 4;
   localparam int DW = (Q > 1) ? $clog2(Q) : 1;
   localparam int IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
      S_DATA_ACK, S_READ, S_MACK, S_STOP, S_DONE
   } state_t;

   state_t                 state, next_state;
   logic [DW-1:0]          div;
   logic [1:0]             ph;
   logic [2:0]             bit_idx;
   logic [IW-1:0]          idx;
   logic [BW-1:0]          count;
   logic                   rw_q;
   logic [6:0]             addr_q;
   logic [8*MAX_BYTES-1:0] wr_q;
   logic [7:0]             shift;
   logic                   ack_bit;
   logic                   start_q;

   logic       start_edge, tick, slot_end, stall, slot_state, last_byte;
   logic       tx_bit, addr_bit;
   logic [7:0] addr_byte, cur_wr, rx_byte;

   assign start_edge = start & ~start_q;
   assign slot_state = state inside {S_ADDR, S_ADDR_ACK, S_WRITE, S_DATA_ACK, S_READ, S_MACK, S_STOP};

`ifdef I2C_CLK_STRETCH_EN
   // A slave holding SCL low in ph2 freezes the bit clock; the high phase restarts on release.
   assign stall = slot_state && (ph == 2'd2) && !scl_in;
`else
   logic scl_unused;
   assign scl_unused = scl_in;
   assign stall      = 1'b0;
`endif

   assign tick      = (state != S_IDLE) && (state != S_DONE) && !stall && (div == DW'(Q - 1));
   assign slot_end  = tick && (ph == 2'd3);
   assign last_byte = (BW'(idx) == count - BW'(1));
   assign addr_byte = {addr_q, rw_q};
   assign addr_bit  = addr_byte[3'd7 - bit_idx];

   always_comb begin
      cur_wr = '0;
      for (int i = 0; i < MAX_BYTES; i++)
         if (idx == IW'(i)) cur_wr = wr_q[8*i +: 8];
   end

   assign tx_bit  = (LSB_FIRST != 0) ? cur_wr[bit_idx] : cur_wr[3'd7 - bit_idx];
   assign rx_byte = (LSB_FIRST != 0) ? {sda_in, shift[7:1]} : {shift[6:0], sda_in};

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:     if (start_edge) next_state = S_START;
         S_START:    if (tick && ph == 2'd1) next_state = S_ADDR;
         S_ADDR:     if (slot_end && bit_idx == 3'd7) next_state = S_ADDR_ACK;
         S_ADDR_ACK: if (slot_end) begin
                        if (ack_bit || count == '0) next_state = S_STOP;
                        else if (rw_q)              next_state = S_READ;
                        else                        next_state = S_WRITE;
                     end
         S_WRITE:    if (slot_end && bit_idx == 3'd7) next_state = S_DATA_ACK;
         S_DATA_ACK: if (slot_end) next_state = (ack_bit || last_byte) ? S_STOP : S_WRITE;
         S_READ:     if (slot_end && bit_idx == 3'd7) next_state = S_MACK;
         S_MACK:     if (slot_end) next_state = last_byte ? S_STOP : S_READ;
         S_STOP:     if (slot_end) next_state = S_DONE;
         S_DONE:     next_state = S_IDLE;
         default:    next_state = S_IDLE;
      endcase
   end

   // NOTE: the latched request (rw_q, addr_q, wr_q) is loaded before every use, so it carries no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_q   <= 1'b0;
         div       <= '0;
         ph        <= '0;
         bit_idx   <= '0;
         idx       <= '0;
         count     <= '0;
         shift     <= '0;
         ack_bit   <= 1'b0;
         ack_error <= 1'b0;
         rd_data   <= '0;
      end else begin
         start_q <= start;

         if (state == S_IDLE || state == S_DONE || stall || div == DW'(Q - 1)) div <= '0;
         else                                                                  div <= div + 1'b1;

         if (state == S_IDLE && start_edge) begin
            rw_q      <= rw;
            addr_q    <= addr;
            wr_q      <= wr_data;
            count     <= (num_bytes > BW'(MAX_BYTES)) ? BW'(MAX_BYTES) : num_bytes;
            ack_error <= 1'b0;
            rd_data   <= '0;
            ph        <= '0;
            bit_idx   <= '0;
            idx       <= '0;
         end

         if (tick) begin
            if (state == S_START && ph == 2'd1) ph <= '0;
            else                                ph <= ph + 2'd1;

            if (ph == 2'd2 && (state == S_ADDR_ACK || state == S_DATA_ACK))
               ack_bit <= sda_in;

            if (ph == 2'd2 && state == S_READ) begin
               shift <= rx_byte;
               if (bit_idx == 3'd7)
                  for (int i = 0; i < MAX_BYTES; i++)
                     if (idx == IW'(i)) rd_data[8*i +: 8] <= rx_byte;
            end
         end

         if (slot_end) begin
            if (state inside {S_ADDR, S_WRITE, S_READ}) bit_idx <= bit_idx + 3'd1;
            if (state inside {S_DATA_ACK, S_MACK})      idx     <= idx + 1'b1;
            if ((state inside {S_ADDR_ACK, S_DATA_ACK}) && ack_bit) ack_error <= 1'b1;
         end
      end
   end

   always_comb begin
      scl_oe = 1'b0;
      sda_oe = 1'b0;
      busy   = (state != S_IDLE);
      done   = (state == S_DONE);
      case (state)
         S_START:    sda_oe = 1'b1;
         S_ADDR:     begin scl_oe = !ph[1]; sda_oe = !addr_bit;  end
         S_WRITE:    begin scl_oe = !ph[1]; sda_oe = !tx_bit;    end
         S_ADDR_ACK,
         S_DATA_ACK,
         S_READ:     scl_oe = !ph[1];
         S_MACK:     begin scl_oe = !ph[1]; sda_oe = !last_byte; end
         S_STOP:     begin scl_oe = !ph[1]; sda_oe = (ph != 2'd3); end
         default:    ;
      endcase
   end
endmodule

// File: tb/tb_i2c_master_rw.sv
// Bench for i2c_master_rw: scripted slave on the open-drain bus, per-cycle slot/phase model, wire decoder.
module tb_i2c_master_rw;
   localparam int CD = 8;
   localparam int MB = 4;
   localparam int Q  = CD / 4;
   localparam int BW = $clog2(MB + 1);

   logic clk = 1'b0;
   logic rst, start, rw;
   logic [6:0]      addr;
   logic [BW-1:0]   num_bytes;
   logic [8*MB-1:0] wr_data, rd_data;
   logic busy, done, ack_error, sda_oe, sda_in, scl_oe, scl_in;
   logic slave_pull = 1'b0;

   assign sda_in = ~(sda_oe | slave_pull);
   assign scl_in = ~scl_oe;

   always #5 clk = ~clk;

   i2c_master_rw #(.CLOCK_DIVIDER(CD), .MAX_BYTES(MB), .LSB_FIRST(0)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .num_bytes(num_bytes),
      .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done), .ack_error(ack_error),
      .sda_oe(sda_oe), .sda_in(sda_in), .scl_oe(scl_oe), .scl_in(scl_in)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: one entry per bit slot (addr, ack, data, master-ack); STOP slot is implicit.
   logic            exp_sda[$];
   logic            slv[$];
   logic [8*MB-1:0] exp_rd;
   logic            exp_err;
   int              model_end;
   int              cyc = 0;
   bit              model_on = 0;
   int              last_done_cyc;

   task automatic build_model(input logic r, input logic [6:0] a, input int n,
                              input logic [8*MB-1:0] wd, input logic [8*MB-1:0] srd, input int nack_at);
      logic [7:0] ab, b;
      int cnt;
      exp_sda.delete();
      slv.delete();
      exp_rd = '0;
      ab = {a, r};
      for (int k = 7; k >= 0; k--) begin exp_sda.push_back(~ab[k]); slv.push_back(1'b0); end
      exp_sda.push_back(1'b0);
      slv.push_back(nack_at != 0);
      exp_err = (nack_at == 0);
      cnt = (n > MB) ? MB : n;
      if (!exp_err) begin
         for (int i = 0; i < cnt; i++) begin
            if (!r) begin
               b = wd[8*i +: 8];
               for (int k = 7; k >= 0; k--) begin exp_sda.push_back(~b[k]); slv.push_back(1'b0); end
               exp_sda.push_back(1'b0);
               slv.push_back(nack_at != i + 1);
               if (nack_at == i + 1) begin exp_err = 1'b1; break; end
            end else begin
               b = srd[8*i +: 8];
               for (int k = 7; k >= 0; k--) begin exp_sda.push_back(1'b0); slv.push_back(~b[k]); end
               exp_rd[8*i +: 8] = b;
               exp_sda.push_back(i != cnt - 1);
               slv.push_back(1'b0);
            end
         end
      end
      model_end = 2*Q + 4*Q*(exp_sda.size() + 1);
   endtask

   // Bus monitor + scripted slave: slot advances on each SCL fall after a START.
   logic wire_scl, wire_sda;
   logic prev_scl = 1'b1, prev_sda = 1'b1;
   int   slot = -1;
   int   n_start = 0, n_stop = 0;
   bit   bus_reset = 0;
   logic mon_bits[$];

   always @(negedge clk) begin
      wire_scl = ~scl_oe;
      wire_sda = sda_in;
      if (prev_scl && wire_scl && prev_sda && !wire_sda) begin n_start++; slot = -1; end
      if (prev_scl && wire_scl && !prev_sda && wire_sda) n_stop++;
      if (!prev_scl && wire_scl) mon_bits.push_back(wire_sda);
      if (prev_scl && !wire_scl) begin
         slot++;
         slave_pull = (slot >= 0 && slot < slv.size()) ? slv[slot] : 1'b0;
      end
      if (bus_reset) begin slave_pull = 1'b0; slot = -1; end
      prev_scl = wire_scl;
      prev_sda = wire_sda;
   end

   // Per-cycle compare against the slot/phase model.
   always @(negedge clk) begin
      int s, p;
      logic e_scl, e_sda, e_busy, e_done;
      if (model_on) begin
         if (cyc < 2*Q) begin
            e_scl = 0; e_sda = 1; e_busy = 1; e_done = 0;
         end else if (cyc < model_end) begin
            s = (cyc - 2*Q) / (4*Q);
            p = ((cyc - 2*Q) % (4*Q)) / Q;
            e_scl  = (p < 2);
            e_sda  = (s < exp_sda.size()) ? exp_sda[s] : (p < 3);
            e_busy = 1; e_done = 0;
         end else if (cyc == model_end) begin
            e_scl = 0; e_sda = 0; e_busy = 1; e_done = 1;
         end else begin
            e_scl = 0; e_sda = 0; e_busy = 0; e_done = 0;
         end
         check($sformatf("scl_oe@%0d", cyc), scl_oe, e_scl);
         check($sformatf("sda_oe@%0d", cyc), sda_oe, e_sda);
         check($sformatf("busy@%0d", cyc), busy, e_busy);
         check($sformatf("done@%0d", cyc), done, e_done);
         cyc++;
         if (cyc > model_end + 2) model_on = 0;
      end
   end

   function automatic logic [7:0] mon_byte(input int k);
      logic [7:0] b;
      b = 8'hxx;
      if (mon_bits.size() >= 9*k + 8)
         for (int j = 0; j < 8; j++) b[7-j] = mon_bits[9*k + j];
      return b;
   endfunction

   function automatic logic mon_ack(input int k);
      return (mon_bits.size() > 9*k + 8) ? mon_bits[9*k + 8] : 1'bx;
   endfunction

   task automatic run_txn(input logic r, input logic [6:0] a, input int n, input logic [8*MB-1:0] wd,
                          input logic [8*MB-1:0] srd, input int nack_at, input int abort_at);
      int st0, sp0;
      bit got;
      build_model(r, a, n, wd, srd, nack_at);
      @(negedge clk);
      rw = r; addr = a; num_bytes = BW'(n); wr_data = wd; start = 1'b1;
      mon_bits.delete();
      st0 = n_start; sp0 = n_stop;
      @(posedge clk); #1;
      cyc = 0;
      model_on = 1;
      got = 0;
      last_done_cyc = -1;
      for (int k = 0; k < model_end + 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            check("ack_error_cleared", ack_error, 1'b0);
            check("rd_data_cleared", rd_data, '0);
         end
         if (k == 2)  start = 1'b0;
         if (k == 30) start = 1'b1;
         if (k == 32) start = 1'b0;
         if (k == abort_at) begin
            model_on = 0;
            check("rd_before_reset", rd_data, 64'h11);
            rst = 1'b1; bus_reset = 1;
            @(negedge clk);
            check("rst_sda_oe", sda_oe, 1'b0);
            check("rst_scl_oe", scl_oe, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_rd_data", rd_data, '0);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            bus_reset = 0;
            repeat (2) @(negedge clk);
            check("rst_idle_busy", busy, 1'b0);
            check("rst_bus_free", sda_in, 1'b1);
            return;
         end
         if (done) begin got = 1; last_done_cyc = k; break; end
      end
      check("done_seen", got, 1'b1);
      check("done_cycle", last_done_cyc, model_end);
      for (int k = 0; k < 10 && model_on; k++) @(negedge clk);
      model_on = 0;
      check("rd_data", rd_data, exp_rd);
      check("ack_error", ack_error, exp_err);
      check("start_conds", n_start - st0, 1);
      check("stop_conds", n_stop - sp0, 1);
      check("wire_bits", mon_bits.size(), exp_sda.size() + 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; num_bytes = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_ack_error", ack_error, 1'b0);
      check("reset_sda_oe", sda_oe, 1'b0);
      check("reset_scl_oe", scl_oe, 1'b0);
      check("reset_rd_data", rd_data, '0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Write 0x3C, two bytes, all ACK.
      run_txn(1'b0, 7'h3C, 2, 32'h0000A501, '0, -1, -1);
      check("w_byte0", mon_byte(0), 8'h78);
      check("w_byte1", mon_byte(1), 8'h01);
      check("w_byte2", mon_byte(2), 8'hA5);
      check("w_ack2", mon_ack(2), 1'b0);
      check("w_ack_error", ack_error, 1'b0);

      // Read 0x50, three bytes 0x11,0x22,0x33.
      run_txn(1'b1, 7'h50, 3, '0, 32'h00332211, -1, -1);
      check("r_addr", mon_byte(0), 8'hA1);
      check("r_byte0", mon_byte(1), 8'h11);
      check("r_byte2", mon_byte(3), 8'h33);
      check("r_mack0", mon_ack(1), 1'b0);
      check("r_mack1", mon_ack(2), 1'b0);
      check("r_mnack", mon_ack(3), 1'b1);
      check("r_rd_data", rd_data[23:0], 24'h332211);

      // Address-only probe to 0x7F, NACKed.
      run_txn(1'b0, 7'h7F, 0, '0, '0, 0, -1);
      check("p_addr", mon_byte(0), 8'hFE);
      check("p_nack", mon_ack(0), 1'b1);
      check("p_bits", mon_bits.size(), 10);
      check("p_done_cycle", last_done_cyc, 84);
      check("p_ack_error", ack_error, 1'b1);

      // Write three bytes, second data byte NACKed.
      run_txn(1'b0, 7'h22, 3, 32'h000C0B0A, '0, 2, -1);
      check("n_byte1", mon_byte(1), 8'h0A);
      check("n_byte2", mon_byte(2), 8'h0B);
      check("n_nack", mon_ack(2), 1'b1);
      check("n_bits", mon_bits.size(), 28);
      check("n_ack_error", ack_error, 1'b1);

      // Read aborted by reset during bit 4 of data byte 1.
      run_txn(1'b1, 7'h50, 3, '0, 32'h00332211, -1, 2*Q + 4*Q*22 + Q);

      // Clean transaction after reset; byte count 7 clamps to 4.
      run_txn(1'b0, 7'h2A, 7, 32'hDEADBEEF, '0, -1, -1);
      check("c_addr", mon_byte(0), 8'h54);
      check("c_byte0", mon_byte(1), 8'hEF);
      check("c_byte3", mon_byte(4), 8'hDE);
      check("c_bits", mon_bits.size(), 46);
      check("c_ack_error", ack_error, 1'b0);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
